// File: rtl/shift_add_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package shift_add_mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t LOAD = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  // Counter must be able to hold the iteration count itself.
  function automatic int unsigned cnt_width(input int unsigned iters);
    return $clog2(iters + 1);
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Multiplicand register, {P_hi, P_lo} accumulator, (m+1)-bit adder and right shifter.
module shift_add_datapath #(
  parameter int unsigned m = 4,
  parameter int unsigned n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           capture,
  input  logic [m-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [m+n-1:0] c
);

  logic [m-1:0] mcand_q;
  logic [m+n:0] acc_q;    // {P_hi[m:0], P_lo[n-1:0]}
  logic [m:0]   sum;
  logic [m+n:0] acc_next;

  always_comb begin
    sum      = acc_q[m+n:n] + (acc_q[0] ? {1'b0, mcand_q} : '0);
    // The adder keeps the carry in P_hi[m]; the shift brings a zero in at the top.
    acc_next = {sum, acc_q[n-1:0]} >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      c       <= '0;
    end else begin
      if (load) begin
        mcand_q <= a;
        acc_q   <= {{(m + 1){1'b0}}, b};
      end else if (step) begin
        acc_q <= acc_next;
      end
      if (capture) begin
        c <= acc_next[m+n-1:0];
      end
    end
  end

endmodule

// File: rtl/shift_and_add_binary_multiplier.sv
// Sequential unsigned m x n multiplier: one LOAD edge, n CALC edges, then holds the product.
module shift_and_add_binary_multiplier
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned m = 4,
  parameter int unsigned n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [m-1:0]   A,
  input  logic [n-1:0]   B,
  output logic [m+n-1:0] C
);

  localparam int unsigned CW = cnt_width(n);
  localparam logic [CW-1:0] LastCnt = CW'(n - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load, step, capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD: begin
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign load    = (state_q == LOAD);
  assign step    = (state_q == CALC);
  assign capture = step && (cnt_q == LastCnt);

  shift_add_datapath #(
    .m(m),
    .n(n)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .capture(capture),
    .a      (A),
    .b      (B),
    .c      (C)
  );

endmodule

// File: tb/tb_shift_and_add_binary_multiplier.sv
// Directed self-checking bench for the 4x4 shift-and-add multiplier.
module tb_shift_and_add_binary_multiplier;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] C;

  int checks;
  int errors;

  shift_and_add_binary_multiplier #(
    .m(4),
    .n(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .A  (A),
    .B  (B),
    .C  (C)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Hold reset for one edge with the operands applied, release before the LOAD edge.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    rst = 1'b0;
    A   = a;
    B   = b;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_edges(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start_op(4'h7, 4'h7);
    wait_edges(5);
    @(negedge clk);
    rst = 1'b0;
    wait_edges(1);
    checks++;
    if (C !== 8'h00) begin
      $display("FAIL reset_clears_c: got %h expected %h", C, 8'h00);
      errors++;
    end
    rst = 1'b1;
  endtask

  task automatic test_max();
    start_op(4'hF, 4'hF);
    for (int e = 1; e <= 4; e++) begin
      wait_edges(1);
      checks++;
      if (C !== 8'h00) begin
        $display("FAIL max_early_edge%0d: got %h expected %h", e, C, 8'h00);
        errors++;
      end
    end
    wait_edges(1);
    checks++;
    if (C !== 8'hE1) begin
      $display("FAIL max_result: got %h expected %h", C, 8'hE1);
      errors++;
    end
  endtask

  task automatic test_hold();
    start_op(4'h3, 4'h3);
    wait_edges(5);
    checks++;
    if (C !== 8'h09) begin
      $display("FAIL hold_result: got %h expected %h", C, 8'h09);
      errors++;
    end
    for (int i = 0; i < 10; i++) begin
      wait_edges(1);
      checks++;
      if (C !== 8'h09) begin
        $display("FAIL hold_cycle%0d: got %h expected %h", i, C, 8'h09);
        errors++;
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] va [3];
    logic [3:0] vb [3];
    logic [7:0] ve [3];
    va = '{4'hC, 4'h0, 4'hF};
    vb = '{4'h2, 4'hF, 4'h0};
    ve = '{8'h18, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      start_op(va[i], vb[i]);
      wait_edges(5);
      checks++;
      if (C !== ve[i]) begin
        $display("FAIL basic_%h_x_%h: got %h expected %h", va[i], vb[i], C, ve[i]);
        errors++;
      end
    end
  endtask

  task automatic test_abort();
    start_op(4'hF, 4'hF);
    wait_edges(2);           // LOAD edge, then first CALC edge
    @(negedge clk);
    rst = 1'b0;              // reset lands on the second CALC edge
    wait_edges(1);
    checks++;
    if (C !== 8'h00) begin
      $display("FAIL abort_c_zero: got %h expected %h", C, 8'h00);
      errors++;
    end
    A = 4'h3;
    B = 4'h3;
    @(negedge clk);
    rst = 1'b1;
    wait_edges(4);
    checks++;
    if (C !== 8'h00) begin
      $display("FAIL abort_restart_early: got %h expected %h", C, 8'h00);
      errors++;
    end
    wait_edges(1);
    checks++;
    if (C !== 8'h09) begin
      $display("FAIL abort_restart_result: got %h expected %h", C, 8'h09);
      errors++;
    end
  endtask

  task automatic test_operand_change();
    logic [3:0] ja [4];
    logic [3:0] jb [4];
    ja = '{4'hF, 4'h1, 4'hA, 4'h0};
    jb = '{4'h0, 4'hE, 4'h7, 4'hF};
    start_op(4'h5, 4'h6);
    wait_edges(1);           // LOAD edge has latched 5 and 6
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A = ja[i];
      B = jb[i];
    end
    #5;                      // past the fifth edge
    checks++;
    if (C !== 8'd30) begin
      $display("FAIL operand_change: got %h expected %h", C, 8'd30);
      errors++;
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(4'(a), 4'(b));
        wait_edges(5);
        exp = 8'(a * b);
        checks++;
        if (C !== exp) begin
          $display("FAIL exhaustive_%0d_x_%0d: got %h expected %h", a, b, C, exp);
          errors++;
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    A      = '0;
    B      = '0;
    wait_edges(1);
    checks++;
    if (C !== 8'h00) begin
      $display("FAIL power_on_reset: got %h expected %h", C, 8'h00);
      errors++;
    end
    test_reset();
    test_max();
    test_hold();
    test_basic();
    test_abort();
    test_operand_change();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
